bus_switch_arbiter: RTL and testbench
=====================================

Name: bus_switch_arbiter

Overview:
- Sequences and shares one bidirectional pass-switch link (tranif1-style) between two bus segments, A and B.
- Each segment has one requester. The block grants exclusive ownership round-robin and drives the switch enable.
- Enforces asymmetric turn-on/turn-off settle intervals (break-before-make) and a bounded hold time.
- Sits between the segment masters and the pass-switch link it controls.

Parameters:
- ON_DLY, 6, cycles from sw_en rise to grant (switch settle); minimum 1.
- OFF_DLY, 2, cycles sw_en stays low after release before the next turn-on; minimum 1.
- MAX_HOLD, 64, owned cycles after which a pending opposite request preempts the owner; minimum 2.
- CW, 8, counter width; must hold max(ON_DLY, OFF_DLY, MAX_HOLD).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_a  input  1  segment A wants to drive across the link; level, held until done.
- req_b  input  1  segment B request; level.
- gnt_a  output  1  A owns the link and may drive.
- gnt_b  output  1  B owns the link.
- sw_en  output  1  pass-switch gate enable.
- dir  output  1  0 = A drives, 1 = B drives; stable whenever sw_en=1 or in TURN_OFF.
- busy  output  1  state is not IDLE.
- timeout_err  output  1  one-cycle pulse on preemption.

Behaviour:
- Reset (async): state=IDLE; gnt_a=gnt_b=sw_en=dir=busy=timeout_err=0; cnt=0; last_owner=B, so A wins the first tie.
- All outputs are registered. At most one of gnt_a/gnt_b is ever high. A grant implies sw_en=1.
- States: IDLE, TURN_ON, OWNED, TURN_OFF.
- IDLE:
  - Any request at an edge → TURN_ON. sw_en=1; dir set to the winner; cnt cleared.
  - Winner: the only requester, or on a tie the side that is not last_owner.
- TURN_ON:
  - cnt increments each cycle.
  - Winner's request still high at edge ON_DLY after entry → OWNED. Grant rises; last_owner set to winner; hold_cnt cleared.
  - Winner's request low at any edge → abort to TURN_OFF. No grant issued; last_owner unchanged.
- OWNED:
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - Owner's request low at an edge → TURN_OFF. Grant and sw_en fall at that same edge.
  - Preemption: hold_cnt==MAX_HOLD-1 and opposite request high at an edge → TURN_OFF. Grant and sw_en fall; timeout_err=1 for one cycle.
  - Owner's request low and preemption coincide → normal release; no timeout_err.
- TURN_OFF:
  - sw_en=0; cnt counts OFF_DLY cycles.
  - At edge OFF_DLY after entry: any request pending → TURN_ON directly, arbitrated as in IDLE. Otherwise → IDLE.
  - Requests during TURN_OFF are only sampled at exit.
- Grant latency: request sampled at edge E0 (from IDLE) → gnt at E0+ON_DLY.
- Minimum gap between one owner's gnt falling and the other's sw_en rising is OFF_DLY cycles.
- rst mid-operation: immediate return to reset values; sw_en drops asynchronously.
- Counters compare with == against parameter-1 values and never wrap.

Decomposition:
- Shared include file bus_switch_defs.vh holds:
  - state encodings (localparam, 2-bit: IDLE=0, TURN_ON=1, OWNED=2, TURN_OFF=3);
  - DIR_A=0 and DIR_B=1.
- One natural sub-module: pass_switch_link. It holds the tranif1 between segment wires, gated by sw_en, and is instantiated beside the arbiter in the segment-level top for integration tests.
- The arbiter itself stays flat.

Test Plan:
- Single request: req_a=1 at E0, held 10 cycles.
  - sw_en=1 and dir=0 from E0; gnt_a=1 at E6.
  - Drop req_a at E16 → gnt_a=0 and sw_en=0 at E16; busy=0 at E18.
- Tie: req_a=req_b=1 from reset release.
  - A granted first.
  - After A drops req_a at edge R: B's sw_en rises at R+2 with dir=1; gnt_b at R+8.
- Abort: req_b rises at E0, falls at E3 (during TURN_ON).
  - No gnt_b ever; sw_en falls at E3; IDLE at E5.
- Preemption with MAX_HOLD=4: A owned at G, req_b high throughout.
  - At G+3: gnt_a=0 and timeout_err=1 (1 cycle).
  - gnt_b at G+3+2+6 = G+11, even though req_a is still high.
- Coincident release and timeout at hold_cnt==MAX_HOLD-1 → timeout_err stays 0; B proceeds normally.
- Async reset asserted mid-OWNED, between edges → gnt and sw_en low immediately.
  - After release with req_a high: full ON_DLY sequence restarts.

Source files
------------

// File: rtl/bus_switch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_switch_arbiter_pkg
// Shared definitions for the A/B pass-switch arbiter and the link model:
//   - 2-bit state encodings (legacy-compatible localparams)
//   - direction encodings (which segment drives across the link)
//   - pick_winner(): round-robin tie-break used on every turn-on decision
// -----------------------------------------------------------------------------
package bus_switch_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TURN_ON  = 2'd1;
  localparam logic [1:0] ST_OWNED    = 2'd2;
  localparam logic [1:0] ST_TURN_OFF = 2'd3;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  // Sole requester wins; on a tie the side that did not own the link last wins.
  // Only meaningful when at least one request is high.
  function automatic logic pick_winner(input logic req_a,
                                       input logic req_b,
                                       input logic last_owner);
    if (req_a && !req_b) return DIR_A;
    if (req_b && !req_a) return DIR_B;
    return ~last_owner;
  endfunction

endpackage

// File: rtl/pass_switch_link.sv
// -----------------------------------------------------------------------------
// pass_switch_link
// Integration model of the pass switch placed between segment A and segment B.
// In silicon this is a tranif1 gated by sw_en; here it is expressed as its
// directional equivalent so it simulates and synthesizes without switch-level
// primitives. The arbiter's dir output selects which segment is the source.
//
// Ports:
//   sw_en      in   switch gate enable from the arbiter
//   dir        in   0 = A drives, 1 = B drives
//   seg_a_drv  in   value segment A puts on its side of the link
//   seg_b_drv  in   value segment B puts on its side of the link
//   seg_a_rx   out  value seen on segment A through the link (0 when open)
//   seg_b_rx   out  value seen on segment B through the link (0 when open)
// -----------------------------------------------------------------------------
module pass_switch_link
  import bus_switch_arbiter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         sw_en,
  input  logic         dir,
  input  logic [W-1:0] seg_a_drv,
  input  logic [W-1:0] seg_b_drv,
  output logic [W-1:0] seg_a_rx,
  output logic [W-1:0] seg_b_rx
);

  assign seg_b_rx = (sw_en && (dir == DIR_A)) ? seg_a_drv : '0;
  assign seg_a_rx = (sw_en && (dir == DIR_B)) ? seg_b_drv : '0;

endmodule

// File: rtl/bus_switch_arbiter.sv
// -----------------------------------------------------------------------------
// bus_switch_arbiter
// Shares one pass-switch link between bus segments A and B. Ownership is
// granted round-robin, the switch is given ON_DLY cycles to settle before a
// grant, OFF_DLY cycles of break-before-make after every release, and an owner
// that has held the link MAX_HOLD cycles is preempted by a waiting opposite
// request.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   req_a/req_b  in   level requests from the segment masters
//   gnt_a/gnt_b  out  ownership grants (never both high, imply sw_en)
//   sw_en        out  pass-switch gate enable
//   dir          out  0 = A drives, 1 = B drives; held through TURN_OFF
//   busy         out  arbiter is not IDLE
//   timeout_err  out  one-cycle pulse when an owner is preempted
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_switch_arbiter
  import bus_switch_arbiter_pkg::*;
#(
  parameter int unsigned ON_DLY   = 6,
  parameter int unsigned OFF_DLY  = 2,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sw_en,
  output logic dir,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_DLY - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_DLY - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold_cnt;
  logic          last_owner;

  logic          win_req;
  logic          opp_req;
  logic          any_req;
  logic          next_dir;
  logic [CW-1:0] hold_nxt;

  // dir always names the current (or pending) owner, so it doubles as the
  // selector for "my request" versus "the other side's request".
  assign win_req  = (dir == DIR_A) ? req_a : req_b;
  assign opp_req  = (dir == DIR_A) ? req_b : req_a;
  assign any_req  = req_a | req_b;
  assign next_dir = pick_winner(req_a, req_b, last_owner);

  // Hold count including the edge being evaluated, saturating so a request
  // that arrives long after the limit still preempts on its first edge.
  assign hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;

  // NOTE: state and outputs share one clocked block with non-blocking
  // assignments only; the async reset branch is what drops sw_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      last_owner  <= DIR_B;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sw_en       <= 1'b0;
      dir         <= DIR_A;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: default first so timeout_err is a single-cycle pulse.
      timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_TURN_ON;
            sw_en <= 1'b1;
            dir   <= next_dir;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_TURN_ON: begin
          cnt <= cnt + 1'b1;
          if (!win_req) begin
            // Abort while settling: no grant, last_owner untouched.
            state <= ST_TURN_OFF;
            sw_en <= 1'b0;
            cnt   <= '0;
          end else if (cnt == ON_LAST) begin
            state      <= ST_OWNED;
            gnt_a      <= (dir == DIR_A);
            gnt_b      <= (dir == DIR_B);
            last_owner <= dir;
            hold_cnt   <= '0;
          end
        end

        ST_OWNED: begin
          hold_cnt <= hold_nxt;
          // Owner release is tested first so a coincident preemption is
          // treated as an ordinary release without timeout_err.
          if (!win_req || (hold_nxt == HOLD_LAST && opp_req)) begin
            state       <= ST_TURN_OFF;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            sw_en       <= 1'b0;
            cnt         <= '0;
            timeout_err <= win_req;
          end
        end

        ST_TURN_OFF: begin
          cnt <= cnt + 1'b1;
          if (cnt == OFF_LAST) begin
            cnt <= '0;
            if (any_req) begin
              state <= ST_TURN_ON;
              sw_en <= 1'b1;
              dir   <= next_dir;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_switch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_switch_arbiter
// Scoreboard bench: each stimulus step pushes the outputs it must produce at
// specific clock edges; a negedge monitor pops and compares them. The arbiter
// runs with MAX_HOLD=4 so preemption is reachable; a pass_switch_link sits
// beside it to confirm the data path follows sw_en/dir.
// -----------------------------------------------------------------------------
module tb_bus_switch_arbiter;
  import bus_switch_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       sw_en;
  logic       dir;
  logic       busy;
  logic       timeout_err;
  logic [7:0] seg_a_drv;
  logic [7:0] seg_b_drv;
  logic [7:0] seg_a_rx;
  logic [7:0] seg_b_rx;

  bus_switch_arbiter #(
    .ON_DLY  (6),
    .OFF_DLY (2),
    .MAX_HOLD(4),
    .CW      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .sw_en      (sw_en),
    .dir        (dir),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  pass_switch_link #(.W(8)) link (
    .sw_en    (sw_en),
    .dir      (dir),
    .seg_a_drv(seg_a_drv),
    .seg_b_drv(seg_b_drv),
    .seg_a_rx (seg_a_rx),
    .seg_b_rx (seg_b_rx)
  );

  always #5 clk = ~clk;

  // Rising edges seen so far; edge E of the test plan is when edge_n becomes E.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef enum logic [2:0] {
    S_GNT_A, S_GNT_B, S_SW_EN, S_DIR, S_BUSY, S_TERR, S_LINK_A, S_LINK_B
  } sig_e;

  typedef struct {
    string       tag;
    int          at_edge;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input int e, input sig_e s, input logic [31:0] v);
    sb.push_back('{tag, e, s, v});
  endtask

  function automatic logic [31:0] sig_val(input sig_e s);
    case (s)
      S_GNT_A:  return 32'(gnt_a);
      S_GNT_B:  return 32'(gnt_b);
      S_SW_EN:  return 32'(sw_en);
      S_DIR:    return 32'(dir);
      S_BUSY:   return 32'(busy);
      S_TERR:   return 32'(timeout_err);
      S_LINK_A: return 32'(seg_a_rx);
      default:  return 32'(seg_b_rx);
    endcase
  endfunction

  // Monitor: invariants every cycle, scoreboard entries at their edge.
  always @(negedge clk) begin
    check("excl_and_sw", 32'((gnt_a & gnt_b) | ((gnt_a | gnt_b) & ~sw_en)), 32'd0);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at_edge == edge_n) begin
        check(sb[i].tag, sig_val(sb[i].sig), sb[i].val);
        sb.delete(i);
      end else if (sb[i].at_edge < edge_n) begin
        check({sb[i].tag, "_late"}, 32'd1, 32'd0);
        sb.delete(i);
      end
    end
  end

  // Returns at the negedge following rising edge e (immediately if already there).
  task automatic at_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int e0;
    int g;
    int r;

    rst       = 1'b1;
    req_a     = 1'b0;
    req_b     = 1'b0;
    seg_a_drv = 8'hA5;
    seg_b_drv = 8'h3C;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_sw_en", 32'(sw_en), 32'd0);
    check("rst_dir",   32'(dir),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);

    // Tie from reset release: A wins, then B after A releases at R.
    req_a = 1'b1;
    req_b = 1'b1;
    rst   = 1'b0;
    e0 = edge_n + 1;
    sb_push("tie_sw_on",  e0,     S_SW_EN, 1);
    sb_push("tie_dir_a",  e0,     S_DIR,   0);
    sb_push("tie_gnta_5", e0 + 5, S_GNT_A, 0);
    sb_push("tie_gnta_6", e0 + 6, S_GNT_A, 1);
    sb_push("tie_gntb_6", e0 + 6, S_GNT_B, 0);
    sb_push("tie_link_b", e0 + 6, S_LINK_B, 32'hA5);
    r = e0 + 7;
    at_edge(r - 1);
    req_a = 1'b0;
    sb_push("tie_rel_gnta", r,     S_GNT_A, 0);
    sb_push("tie_rel_sw",   r,     S_SW_EN, 0);
    sb_push("tie_rel_terr", r,     S_TERR,  0);
    sb_push("tie_rel_linkb", r,    S_LINK_B, 0);
    sb_push("tie_gap_sw",   r + 1, S_SW_EN, 0);
    sb_push("tie_b_sw",     r + 2, S_SW_EN, 1);
    sb_push("tie_b_dir",    r + 2, S_DIR,   1);
    sb_push("tie_gntb_7",   r + 7, S_GNT_B, 0);
    sb_push("tie_gntb_8",   r + 8, S_GNT_B, 1);
    sb_push("tie_link_a",   r + 8, S_LINK_A, 32'h3C);
    at_edge(r + 8);
    req_b = 1'b0;
    sb_push("tie_end_gntb", r + 9,  S_GNT_B, 0);
    sb_push("tie_end_busy1", r + 10, S_BUSY, 1);
    sb_push("tie_end_busy0", r + 11, S_BUSY, 0);
    at_edge(r + 13);

    // Abort: req_b high E0..E2, low at E3 during TURN_ON.
    e0 = edge_n + 1;
    req_b = 1'b1;
    sb_push("abt_sw_on", e0, S_SW_EN, 1);
    sb_push("abt_dir_b", e0, S_DIR,   1);
    for (int k = 0; k <= 6; k++) sb_push($sformatf("abt_nogntb_%0d", k), e0 + k, S_GNT_B, 0);
    at_edge(e0 + 2);
    req_b = 1'b0;
    sb_push("abt_sw_off", e0 + 3, S_SW_EN, 0);
    sb_push("abt_busy4",  e0 + 4, S_BUSY,  1);
    sb_push("abt_busy5",  e0 + 5, S_BUSY,  0);
    at_edge(e0 + 8);

    // Single request held 10 owned cycles.
    e0 = edge_n + 1;
    req_a = 1'b1;
    sb_push("one_sw_on",  e0,      S_SW_EN, 1);
    sb_push("one_dir_a",  e0,      S_DIR,   0);
    sb_push("one_busy",   e0,      S_BUSY,  1);
    sb_push("one_gnta_5", e0 + 5,  S_GNT_A, 0);
    sb_push("one_gnta_6", e0 + 6,  S_GNT_A, 1);
    sb_push("one_gnta_15", e0 + 15, S_GNT_A, 1);
    at_edge(e0 + 15);
    req_a = 1'b0;
    sb_push("one_rel_gnta", e0 + 16, S_GNT_A, 0);
    sb_push("one_rel_sw",   e0 + 16, S_SW_EN, 0);
    sb_push("one_rel_terr", e0 + 16, S_TERR,  0);
    sb_push("one_busy17",   e0 + 17, S_BUSY,  1);
    sb_push("one_busy18",   e0 + 18, S_BUSY,  0);
    at_edge(e0 + 20);

    // Preemption (MAX_HOLD=4): A owned at G, req_b high throughout.
    e0 = edge_n + 1;
    req_a = 1'b1;
    g = e0 + 6;
    at_edge(e0 + 1);
    req_b = 1'b1;
    sb_push("pre_gnta_g",  g,      S_GNT_A, 1);
    sb_push("pre_gnta_2",  g + 2,  S_GNT_A, 1);
    sb_push("pre_terr_2",  g + 2,  S_TERR,  0);
    sb_push("pre_gnta_3",  g + 3,  S_GNT_A, 0);
    sb_push("pre_sw_3",    g + 3,  S_SW_EN, 0);
    sb_push("pre_terr_3",  g + 3,  S_TERR,  1);
    sb_push("pre_terr_4",  g + 4,  S_TERR,  0);
    sb_push("pre_sw_5",    g + 5,  S_SW_EN, 1);
    sb_push("pre_dir_5",   g + 5,  S_DIR,   1);
    sb_push("pre_gntb_10", g + 10, S_GNT_B, 0);
    sb_push("pre_gntb_11", g + 11, S_GNT_B, 1);
    sb_push("pre_gnta_11", g + 11, S_GNT_A, 0);
    sb_push("pre_b_out",   g + 14, S_GNT_B, 0);
    sb_push("pre_b_terr",  g + 14, S_TERR,  1);
    sb_push("pre_a_dir",   g + 16, S_DIR,   0);
    sb_push("pre_a_gnt",   g + 22, S_GNT_A, 1);
    at_edge(g + 22);
    req_a = 1'b0;
    req_b = 1'b0;
    sb_push("pre_end_gnta", g + 23, S_GNT_A, 0);
    sb_push("pre_end_terr", g + 23, S_TERR,  0);
    sb_push("pre_end_busy", g + 25, S_BUSY,  0);
    at_edge(g + 28);

    // Coincident release and limit: A drops on the preemption edge.
    e0 = edge_n + 1;
    req_a = 1'b1;
    g = e0 + 6;
    at_edge(e0);
    req_b = 1'b1;
    sb_push("co_gnta_g",  g,      S_GNT_A, 1);
    at_edge(g + 2);
    req_a = 1'b0;
    sb_push("co_gnta_3",  g + 3,  S_GNT_A, 0);
    sb_push("co_terr_3",  g + 3,  S_TERR,  0);
    sb_push("co_terr_4",  g + 4,  S_TERR,  0);
    sb_push("co_sw_5",    g + 5,  S_SW_EN, 1);
    sb_push("co_dir_5",   g + 5,  S_DIR,   1);
    sb_push("co_gntb_11", g + 11, S_GNT_B, 1);
    at_edge(g + 11);
    req_b = 1'b0;
    sb_push("co_gntb_12", g + 12, S_GNT_B, 0);
    sb_push("co_busy_14", g + 14, S_BUSY,  0);
    at_edge(g + 16);

    // Async reset between edges while A owns the link.
    e0 = edge_n + 1;
    req_a = 1'b1;
    g = e0 + 6;
    sb_push("ar_gnta_g", g, S_GNT_A, 1);
    at_edge(g + 1);
    #2 rst = 1'b1;
    #1;
    check("ar_gnta_now", 32'(gnt_a), 32'd0);
    check("ar_sw_now",   32'(sw_en), 32'd0);
    check("ar_busy_now", 32'(busy),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    e0 = edge_n + 1;
    sb_push("ar_sw_on",  e0,     S_SW_EN, 1);
    sb_push("ar_dir_a",  e0,     S_DIR,   0);
    sb_push("ar_gnta_5", e0 + 5, S_GNT_A, 0);
    sb_push("ar_gnta_6", e0 + 6, S_GNT_A, 1);
    at_edge(e0 + 7);
    req_a = 1'b0;
    sb_push("ar_busy_end", e0 + 10, S_BUSY, 0);
    at_edge(e0 + 13);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
